datapath_gen: RTL
=================

Name: datapath_gen

Overview:
- Parametrised successor of the MCU datapath: register file, program counter (PC), instruction register (IR), segment register (SR), status register, two internal buses (bus1 from mux1, bus2 from mux2).
- Hardware link stack replaces the single link register.
- Single-cycle RAM replaced by a req/ack data-memory port with stall reporting.
- ALU stays external: it is fed from out1/bus1 and returns result and flags.

Parameters:
- DATA_W, 8: data word width; bus width is 2*DATA_W.
- REG_AW, 3: register-file address width; 2**REG_AW registers.
- SEG_W, 2: segment register bits used in the data address.
- LR_DEPTH, 4: link stack entries (>=2).
- PC_STEP, 2: PC increment per incPC.

Ports:
- clock  in  1  rising-edge clock
- Rst  in  1  synchronous active-high reset
- a1, a2, aWrite  in  REG_AW each  register read/read/write addresses
- loadReg  in  1  register write enable
- selDataReg  in  1  register write data: 0 = bus2 low byte, 1 = high-byte buffer
- loadB2MB  in  1  capture bus2 high byte into high-byte buffer
- incPC, loadPCL, loadPCH  in  1 each  PC control
- loadIRL, loadIRH  in  1 each  IR byte loads from bus2
- selMux1  in  2  bus1 source
- selMux2  in  3  bus2 source
- loadSR  in  1  SR <= bus1 low byte
- pushLR, popLR  in  1 each  link stack control
- memRd, memWr  in  1 each  data-memory request strobes
- memReq  out  1  request held to memory
- memWe  out  1  write qualifier, valid while memReq
- memAddr  out  SEG_W+DATA_W  {SR[SEG_W-1:0], IR[DATA_W-1:0]}, latched
- memWData  out  DATA_W  write data, latched
- memRData  in  DATA_W  read data, valid with memAck
- memAck  in  1  completes request
- busy  out  1  memory transaction outstanding
- aluIn  in  2*DATA_W  ALU result
- aluFlags  in  6  {OV,C,B,T,Z,DIV0}
- loadStatus  in  1  status <= {2'b0, aluFlags}
- extIn  in  DATA_W  external input byte
- out1  out  DATA_W  register read port 1 (to ALU)
- bus1  out  2*DATA_W  bus1 (to ALU operand B)
- IROut  out  2*DATA_W  IR
- SROut, StatusOut  out  DATA_W each
- lrFull, lrEmpty  out  1 each  link stack state

Behaviour:
- Reset (Rst high at edge): all registers, PC, IR, SR, status, high-byte buffer, read-data buffer, link stack and count cleared; memReq=0, memWe=0, busy=0, lrEmpty=1, lrFull=0. Reset mid-transaction abandons it; a late memAck is ignored.
- Register file: 2 asynchronous reads, 1 synchronous write. Read during write returns the old value.
- mux1 select: 0 = {0, out2}; 1 = PC; 2 = {0, IR low}; 3 = 0.
- mux2 select: 0 = aluIn; 1 = {0, extIn}; 2 = {SR, 0}; 3 = bus1; 4 = link top; 5 = {0, read-data buffer}; 6 = {0, StatusOut}; 7 = 0.
- PC: loadPCH/loadPCL load the high/low byte from bus2; both may load together. Any load has priority over incPC. Increment is PC+PC_STEP, modulo 2**(2*DATA_W).
- IR: loadIRH/loadIRL load bytes independently.
- Link stack:
  - pushLR writes bus1 to the top.
  - popLR discards the top.
  - Top (mux2 select 4) is 0 when empty.
  - Push when full: oldest entry dropped; count stays LR_DEPTH.
  - Pop when empty: no change.
  - Push and pop in the same cycle: top replaced, count unchanged.
- Memory FSM:
  - IDLE: memRd or memWr with busy=0 → latch address and memWData=bus1 low byte, set memWe=memWr, go REQ. memReq and busy rise the next cycle.
  - Both strobes high: write wins.
  - REQ: hold memReq/addr/data stable; busy=1.
  - memAck in REQ: if read, capture memRData into the read-data buffer. Return to IDLE; memReq and busy fall the next cycle; the buffer is readable that cycle.
  - Strobes while busy are ignored.
  - memAck outside REQ is ignored.
  - Ack in the first REQ cycle is legal, giving minimum latency of 2 cycles strobe→data available.
- Status updates only on loadStatus.

Test Plan:
- Reset: drive activity, assert Rst one cycle → all outputs 0, lrEmpty=1, busy=0, mux2 select 4 gives 0.
- PC: load 0x12FE via loadPCH+loadPCL, then incPC → 0x1300. incPC+loadPCL with bus2 = 0x0055 → PC = 0x1355.
- Link stack (LR_DEPTH=4): push 1,2,3,4,5 → lrFull=1; pops read 5,4,3,2, then lrEmpty=1. Push+pop with top 7 and bus1 = 9 → top = 9, count unchanged.
- Memory read: SR=2, IR low=0x34, memRd; ack after 3 wait cycles with 0xA5 → memAddr=0x234 held stable throughout; busy high 4 cycles; mux2 select 5 gives 0x00A5; a memRd while busy is dropped.
- Memory write: bus1 = 0x3C, memWr+memRd together → memWe=1, memWData=0x3C. Rst while in REQ → memReq=0 next cycle; a following memAck is ignored.
- Register file: write 0xAB via bus2 low (selDataReg=0) to r5; write high-byte buffer 0xCD (loadB2MB) to r6; read a1=5, a2=6 → out1=0xAB, bus1 (selMux1=0) = 0x00CD.

Source files
------------

// File: rtl/datapath_gen.sv
// datapath_gen: parametrised MCU datapath with register file, PC, IR, SR,
// status, two internal buses, hardware link stack and a req/ack data port.
module datapath_gen #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned REG_AW   = 3,
  parameter int unsigned SEG_W    = 2,
  parameter int unsigned LR_DEPTH = 4,
  parameter int unsigned PC_STEP  = 2
) (
  input  logic                    clock,
  input  logic                    Rst,
  input  logic [REG_AW-1:0]       a1,
  input  logic [REG_AW-1:0]       a2,
  input  logic [REG_AW-1:0]       aWrite,
  input  logic                    loadReg,
  input  logic                    selDataReg,
  input  logic                    loadB2MB,
  input  logic                    incPC,
  input  logic                    loadPCL,
  input  logic                    loadPCH,
  input  logic                    loadIRL,
  input  logic                    loadIRH,
  input  logic [1:0]              selMux1,
  input  logic [2:0]              selMux2,
  input  logic                    loadSR,
  input  logic                    pushLR,
  input  logic                    popLR,
  input  logic                    memRd,
  input  logic                    memWr,
  output logic                    memReq,
  output logic                    memWe,
  output logic [SEG_W+DATA_W-1:0] memAddr,
  output logic [DATA_W-1:0]       memWData,
  input  logic [DATA_W-1:0]       memRData,
  input  logic                    memAck,
  output logic                    busy,
  input  logic [2*DATA_W-1:0]     aluIn,
  input  logic [5:0]              aluFlags,
  input  logic                    loadStatus,
  input  logic [DATA_W-1:0]       extIn,
  output logic [DATA_W-1:0]       out1,
  output logic [2*DATA_W-1:0]     bus1,
  output logic [2*DATA_W-1:0]     IROut,
  output logic [DATA_W-1:0]       SROut,
  output logic [DATA_W-1:0]       StatusOut,
  output logic                    lrFull,
  output logic                    lrEmpty
);

  localparam int unsigned BW   = 2 * DATA_W;
  localparam int unsigned NREG = 2 ** REG_AW;
  localparam int unsigned CW   = $clog2(LR_DEPTH + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;

  logic [DATA_W-1:0]       r_regs [NREG];
  logic [BW-1:0]           r_pc;
  logic [BW-1:0]           r_ir;
  logic [DATA_W-1:0]       r_sr;
  logic [DATA_W-1:0]       r_status;
  logic [DATA_W-1:0]       r_hb;
  logic [DATA_W-1:0]       r_rdbuf;
  logic [BW-1:0]           r_lr [LR_DEPTH];
  logic [CW-1:0]           r_lr_cnt;
  logic [0:0]              r_state;
  logic                    r_we;
  logic [SEG_W+DATA_W-1:0] r_addr;
  logic [DATA_W-1:0]       r_wdata;

  logic [DATA_W-1:0]       w_out2;
  logic [BW-1:0]           w_bus2;
  logic [BW-1:0]           w_lr_top;

  assign out1      = r_regs[a1];
  assign w_out2    = r_regs[a2];
  assign w_lr_top  = (r_lr_cnt == '0) ? '0 : r_lr[0];
  assign IROut     = r_ir;
  assign SROut     = r_sr;
  assign StatusOut = r_status;
  assign lrEmpty   = (r_lr_cnt == '0);
  assign lrFull    = (r_lr_cnt == CW'(LR_DEPTH));
  assign memReq    = (r_state == S_REQ);
  assign busy      = (r_state == S_REQ);
  assign memWe     = (r_state == S_REQ) && r_we;
  assign memAddr   = r_addr;
  assign memWData  = r_wdata;

  // bus1 source select
  always_comb begin
    bus1 = '0;
    case (selMux1)
      2'd0:    bus1 = {{DATA_W{1'b0}}, w_out2};
      2'd1:    bus1 = r_pc;
      2'd2:    bus1 = {{DATA_W{1'b0}}, r_ir[DATA_W-1:0]};
      default: bus1 = '0;
    endcase
  end

  // bus2 source select
  always_comb begin
    w_bus2 = '0;
    case (selMux2)
      3'd0:    w_bus2 = aluIn;
      3'd1:    w_bus2 = {{DATA_W{1'b0}}, extIn};
      3'd2:    w_bus2 = {r_sr, {DATA_W{1'b0}}};
      3'd3:    w_bus2 = bus1;
      3'd4:    w_bus2 = w_lr_top;
      3'd5:    w_bus2 = {{DATA_W{1'b0}}, r_rdbuf};
      3'd6:    w_bus2 = {{DATA_W{1'b0}}, r_status};
      default: w_bus2 = '0;
    endcase
  end

  // Register file write port and high-byte buffer
  always_ff @(posedge clock) begin
    if (Rst) begin
      for (int unsigned i = 0; i < NREG; i++) r_regs[i] <= '0;
      r_hb <= '0;
    end else begin
      if (loadReg) r_regs[aWrite] <= selDataReg ? r_hb : w_bus2[DATA_W-1:0];
      if (loadB2MB) r_hb <= w_bus2[BW-1:DATA_W];
    end
  end

  // PC: byte loads take priority over increment
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_pc <= '0;
    end else if (loadPCH || loadPCL) begin
      if (loadPCH) r_pc[BW-1:DATA_W] <= w_bus2[BW-1:DATA_W];
      if (loadPCL) r_pc[DATA_W-1:0]  <= w_bus2[DATA_W-1:0];
    end else if (incPC) begin
      r_pc <= r_pc + BW'(PC_STEP);
    end
  end

  // IR, SR and status registers
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_ir     <= '0;
      r_sr     <= '0;
      r_status <= '0;
    end else begin
      if (loadIRH)    r_ir[BW-1:DATA_W] <= w_bus2[BW-1:DATA_W];
      if (loadIRL)    r_ir[DATA_W-1:0]  <= w_bus2[DATA_W-1:0];
      if (loadSR)     r_sr              <= bus1[DATA_W-1:0];
      if (loadStatus) r_status          <= {{(DATA_W-6){1'b0}}, aluFlags};
    end
  end

  // Link stack as a shift register with entry 0 on top; overflow drops the
  // bottom entry, so the count saturates at LR_DEPTH.
  always_ff @(posedge clock) begin
    if (Rst) begin
      for (int unsigned i = 0; i < LR_DEPTH; i++) r_lr[i] <= '0;
      r_lr_cnt <= '0;
    end else if (pushLR && popLR) begin
      r_lr[0] <= bus1;
    end else if (pushLR) begin
      for (int unsigned i = 1; i < LR_DEPTH; i++) r_lr[i] <= r_lr[i-1];
      r_lr[0] <= bus1;
      if (r_lr_cnt != CW'(LR_DEPTH)) r_lr_cnt <= r_lr_cnt + 1'b1;
    end else if (popLR && (r_lr_cnt != '0)) begin
      for (int unsigned i = 0; i < LR_DEPTH - 1; i++) r_lr[i] <= r_lr[i+1];
      r_lr[LR_DEPTH-1] <= '0;
      r_lr_cnt <= r_lr_cnt - 1'b1;
    end
  end

  // Data-memory request FSM: latch request on strobe, wait for ack
  always_ff @(posedge clock) begin
    if (Rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdbuf <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (memRd || memWr) begin
            r_we    <= memWr;
            r_addr  <= {r_sr[SEG_W-1:0], r_ir[DATA_W-1:0]};
            r_wdata <= bus1[DATA_W-1:0];
            r_state <= S_REQ;
          end
        end
        default: begin
          if (memAck) begin
            if (!r_we) r_rdbuf <= memRData;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
